input_interface: RTL and testbench
==================================

INPUT_INTERFACE -- requirements
Module: input_interface

Interface
REQ-001 Parameter WIDTH, default 4: number of independent button channels.
REQ-002 Parameter DB_CYC, default 500000: consecutive equal samples needed to accept a press or a release.
REQ-003 Parameter HOLD_CYC, default 50000000: cycles from the first MCEN pulse to the first auto-repeat MCEN pulse.
REQ-004 Parameter REP_CYC, default 10000000: period between auto-repeat MCEN pulses.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 buttons  input  WIDTH  raw, asynchronous, bouncy push-buttons; 1 = pressed.
REQ-008 DPBs  output  WIDTH  debounced button level, one bit per channel.
REQ-009 SCENs  output  WIDTH  single clock enable: one-cycle pulse per accepted press.
REQ-010 MCENs  output  WIDTH  multiple clock enable: press pulse plus auto-repeat pulses while held.
REQ-011 CCENs  output  WIDTH  continuous clock enable: high every cycle of an accepted press.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and REL_WAIT; channels SHALL NOT interact.
REQ-013 All outputs SHALL be registered and SHALL update on the clock edge at which the FSM changes state.
REQ-014 IDLE: all outputs 0; a sample of 1 -> PRESS_WAIT, with the count set to 1.
REQ-015 PRESS_WAIT: each further 1 increments the count; any 0 -> IDLE with no output activity; on the DB_CYC-th consecutive 1 -> HELD.
REQ-016 Entry to HELD: on that edge DPB=1, SCEN=1, MCEN=1 and CCEN=1; SCEN and MCEN SHALL drop after exactly one cycle.
REQ-017 HELD: DPB=1 and CCEN=1; MCEN pulses for one cycle HOLD_CYC cycles after the entry pulse, then every REP_CYC cycles.
REQ-018 HELD: a sample of 0 -> REL_WAIT with the count set to 1.
REQ-019 REL_WAIT: DPB stays 1, CCEN=0, and the repeat timer is frozen with MCEN suppressed.
REQ-020 REL_WAIT: a sample of 1 -> back to HELD with no SCEN pulse, and the repeat timer resumes.
REQ-021 REL_WAIT: on the DB_CYC-th consecutive 0 -> IDLE, and DPB=0 on that edge.
REQ-022 SCEN SHALL fire exactly once per accepted press, regardless of hold length or release bounce.
REQ-023 Counters SHALL be $clog2-sized to their largest limit and SHALL saturate, never wrap.
REQ-024 Simultaneous presses on several channels SHALL produce their pulses in the same cycle when their samples align.

Reset
REQ-025 reset SHALL asynchronously force every channel to IDLE, clear all counters and drive DPBs, SCENs, MCENs and CCENs to 0.
REQ-026 Reset asserted mid-press SHALL discard the press; after reset deasserts, a full DB_CYC debounce SHALL be required again.

Configuration
REQ-027 With macro INPUT_INTERFACE_SYNC_EN defined, each button SHALL pass through a 2-flop synchronizer (reset to 0) before its FSM.
REQ-028 With INPUT_INTERFACE_SYNC_EN defined, every response SHALL occur 2 edges later than specified here.
REQ-029 Without INPUT_INTERFACE_SYNC_EN, the FSM SHALL sample buttons directly; all timings in this document assume this case.

Structure
REQ-030 Package input_interface_pkg SHALL hold the FSM state typedef and the default DB_CYC, HOLD_CYC and REP_CYC constants.
REQ-031 The top SHALL generate WIDTH instances of sub-module debounce_channel (1-bit in; DPB, SCEN, MCEN and CCEN out), plus the optional synchronizer.

Verification (DB_CYC=4, HOLD_CYC=8, REP_CYC=3, sync disabled, button first sampled at edge 0)
REQ-032 buttons[0]=1 held -> DPB[0], SCEN[0], MCEN[0] and CCEN[0] rise after edge 3; SCEN[0] is low after edge 4; other bits stay 0.
REQ-033 buttons[0]=1 for 3 edges, then 0 -> all outputs stay 0 throughout.
REQ-034 Hold buttons[0] from edge 0 -> MCEN[0] pulses after edges 3, 11, 14 and 17; CCEN[0] stays high continuously; SCEN[0] pulses only once.
REQ-035 Release at edge 20 with pattern 0,0,1,0,0,0,0 -> DPB[0] stays 1, no new SCEN[0]; DPB[0] falls after the 4th consecutive 0.
REQ-036 buttons[1] and buttons[3] rise at the same edge -> SCENs = 4'b1010 for exactly one cycle.
REQ-037 reset pulsed while buttons[2] is in HELD -> all outputs read 0 immediately, without waiting for a clock edge; with buttons[2] still high, SCEN[2] fires after 4 edges.

Source files
------------

// File: rtl/input_interface_pkg.sv
// Shared types and default timing constants for the button input interface.
package input_interface_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } db_state_e;

    localparam int DB_CYC_DEF   = 500000;
    localparam int HOLD_CYC_DEF = 50000000;
    localparam int REP_CYC_DEF  = 10000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: debounce plus single, repeating and continuous clock enables.
//   state      | meaning
//   IDLE       | released, all outputs low
//   PRESS_WAIT | counting consecutive pressed samples
//   HELD       | accepted press, repeat timer running
//   REL_WAIT   | counting consecutive released samples, repeat timer frozen
module debounce_channel
    import input_interface_pkg::*;
#(
    parameter int DB_CYC   = DB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic dpb_o,
    output logic scen_o,
    output logic mcen_o,
    output logic ccen_o
);

    localparam int TMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW   = $clog2(DB_CYC + 1);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REP_LOAD  = TW'(REP_CYC - 1);

    db_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmr_q;
    logic            dpb_q, scen_q, mcen_q, ccen_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
            ccen_q  <= 1'b0;
        end else begin
            scen_q <= 1'b0;
            mcen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_i) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= DB_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        tmr_q   <= HOLD_LOAD;
                        dpb_q   <= 1'b1;
                        scen_q  <= 1'b1;
                        mcen_q  <= 1'b1;
                        ccen_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn_i) begin
                        state_q <= REL_WAIT;
                        cnt_q   <= CW'(1);
                        ccen_q  <= 1'b0;
                    end else if (tmr_q == '0) begin
                        mcen_q <= 1'b1;
                        tmr_q  <= REP_LOAD;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                REL_WAIT: begin
                    // A bounce back to pressed resumes the hold without a new press pulse.
                    if (btn_i) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        ccen_q  <= 1'b1;
                    end else if (cnt_q >= DB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        tmr_q   <= '0;
                        dpb_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dpb_o  = dpb_q;
    assign scen_o = scen_q;
    assign mcen_o = mcen_q;
    assign ccen_o = ccen_q;

endmodule

// File: rtl/input_interface.sv
// WIDTH independent debounced button channels.
// Define INPUT_INTERFACE_SYNC_EN to add a 2-flop synchronizer in front of each channel.
module input_interface
    import input_interface_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DB_CYC   = DB_CYC_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] DPBs,
    output logic [WIDTH-1:0] SCENs,
    output logic [WIDTH-1:0] MCENs,
    output logic [WIDTH-1:0] CCENs
);

    logic [WIDTH-1:0] btn_s;

`ifdef INPUT_INTERFACE_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = buttons;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DB_CYC   (DB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .REP_CYC  (REP_CYC)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_s[i]),
            .dpb_o  (DPBs[i]),
            .scen_o (SCENs[i]),
            .mcen_o (MCENs[i]),
            .ccen_o (CCENs[i])
        );
    end

endmodule

// File: tb/tb_input_interface.sv
// Scoreboard bench for input_interface with short debounce/hold/repeat timings.
module tb_input_interface;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] buttons;
    logic [W-1:0] DPBs, SCENs, MCENs, CCENs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    input_interface #(
        .WIDTH    (W),
        .DB_CYC   (4),
        .HOLD_CYC (8),
        .REP_CYC  (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .DPBs    (DPBs),
        .SCENs   (SCENs),
        .MCENs   (MCENs),
        .CCENs   (CCENs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (DPB|SCEN|MCEN|CCEN)", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {DPBs, SCENs, MCENs, CCENs};
    endfunction

    // Place a per-channel {dpb,scen,mcen,ccen} nibble into the packed output word.
    function automatic logic [15:0] pack(input int ch, input logic [3:0] v);
        logic [15:0] r;
        r = '0;
        r[12+ch] = v[3];
        r[8+ch]  = v[2];
        r[4+ch]  = v[1];
        r[ch]    = v[0];
        return r;
    endfunction

    // Button held from edge 0: accepted after edge 3, repeat timer far off.
    function automatic logic [3:0] exp_press(input int k);
        if (k < 3) return 4'b0000;
        return {1'b1, k == 3, k == 3, 1'b1};
    endfunction

    // Held edges 0..19, then released with pattern 0,0,1,0,0,0,0 from edge 20.
    function automatic logic [3:0] exp_hold(input int k);
        logic mc;
        mc = (k == 3) || (k == 11) || (k == 14) || (k == 17);
        if (k < 3)   return 4'b0000;
        if (k <= 19) return {1'b1, k == 3, mc, 1'b1};
        if (k == 22) return 4'b1001;
        if (k <= 25) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic step(input logic [W-1:0] b, input logic [15:0] exp, input string tag);
        sb_item_t it;
        buttons = b;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 16'hFFFF, 16'h0000);
        end else begin
            it = sb_q.pop_front();
            chk(it.tag, outs(), it.exp);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
    task automatic rst_pulse(input string tag);
        #2 reset = 1'b1;
        #1 chk(tag, outs(), 16'h0000);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        buttons = '0;
        #3 chk("reset_state", outs(), 16'h0000);
        @(posedge clk);
        #1 chk("reset_held", outs(), 16'h0000);
        reset = 1'b0;

        for (int k = 0; k < 30; k++) begin
            logic b0;
            b0 = (k < 20) ? 1'b1 : (k == 22);
            step({3'b000, b0}, pack(0, exp_hold(k)), $sformatf("hold_e%0d", k));
        end

        for (int k = 0; k < 7; k++)
            step((k < 3) ? 4'b0001 : 4'b0000, 16'h0000, $sformatf("short_e%0d", k));

        for (int k = 0; k < 6; k++)
            step(4'b1010, pack(1, exp_press(k)) | pack(3, exp_press(k)),
                 $sformatf("simul_e%0d", k));
        rst_pulse("rst_after_simul");

        for (int k = 0; k < 6; k++)
            step(4'b0100, pack(2, exp_press(k)), $sformatf("pre_rst_e%0d", k));
        rst_pulse("rst_in_held");
        for (int k = 0; k < 6; k++)
            step(4'b0100, pack(2, exp_press(k)), $sformatf("post_rst_e%0d", k));

        chk("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
